cap_current_estimator: RTL and testbench

Inverse of the capacitor integrator model: consumes a stream of sampled capacitor voltage codes and recovers the charging current via I = (C/Ts)·ΔV. It sits downstream of the capacitor/ADC sample path. Its output is checked against the stimulus current applied to the integrator (1 uA nominal, C = 100 nF, Ts = 4 ns, so C/Ts = 25). Fixed-point, synthesizable, with valid/ready on both sides.

---
 rtl/cap_current_estimator.sv | 142 ++++++++++++++
 tb/tb_cap_current_estimator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cap_current_estimator.sv
// Recovers capacitor charging current from sampled voltage codes: m_i = clamp((dV * GAIN) >>> SHIFT).
// Latency: a sample accepted at edge k drives m_valid after edge k+2; one sample per clock when unstalled.
// Backpressure: the pipeline advances only when !m_valid || m_ready; a stall freezes every stage and drops s_ready.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   clear            synchronous flush: empties the pipeline, re-primes, zeroes sample_cnt/sat_sticky
//   s_valid/s_ready  input handshake, s_vout is the signed voltage sample code
//   m_valid/m_ready  output handshake, m_i is the signed current estimate, m_sat flags a clamped m_i
//   sample_cnt       count of delivered outputs, saturating at all-ones
//   sat_sticky       set by any delivered saturated output
module cap_current_estimator #(
   parameter int V_W   = 24,
   parameter int I_W   = 16,
   parameter int GAIN  = 25,
   parameter int SHIFT = 0,
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic signed [V_W-1:0] s_vout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic signed [I_W-1:0] m_i,
   output logic                  m_sat,
   output logic [CNT_W-1:0]      sample_cnt,
   output logic                  sat_sticky
);

   // Difference needs one extra bit; the product adds 13 bits for a gain up to 2^12-1 treated as signed.
   localparam int D_W = V_W + 1;
   localparam int P_W = V_W + 1 + 13;

   localparam logic signed [P_W-1:0] GAIN_P = P_W'(GAIN);
   localparam logic signed [P_W-1:0] I_MAX  = {{(P_W-I_W+1){1'b0}}, {(I_W-1){1'b1}}};
   localparam logic signed [P_W-1:0] I_MIN  = {{(P_W-I_W+1){1'b1}}, {(I_W-1){1'b0}}};

   typedef enum logic {EMPTY, PRIMED} state_t;

   state_t                state;
   logic                  run_en;     // low during reset and until the first edge after release
   logic signed [V_W-1:0] v_prev;
   logic                  s1_vld;
   logic signed [D_W-1:0] s1_d;
   logic                  s2_vld;
   logic signed [P_W-1:0] s2_p;

   logic                  advance;
   logic                  accept;
   logic signed [D_W-1:0] diff;
   logic signed [P_W-1:0] d_ext;
   logic signed [P_W-1:0] prod;
   logic signed [P_W-1:0] q;
   logic signed [I_W-1:0] clamp_i;
   logic                  clamp_sat;

   assign advance = !m_valid || m_ready;
   assign s_ready = run_en && advance && !clear;
   assign accept  = s_valid && s_ready;

   // Explicit sign extension keeps the subtraction overflow-free.
   assign diff  = {s_vout[V_W-1], s_vout} - {v_prev[V_W-1], v_prev};
   assign d_ext = {{(P_W-D_W){s1_d[D_W-1]}}, s1_d};
   assign prod  = d_ext * GAIN_P;
   assign q     = s2_p >>> SHIFT;

   always_comb begin
      clamp_i   = q[I_W-1:0];
      clamp_sat = 1'b0;
      if (q > I_MAX) begin
         clamp_i   = I_MAX[I_W-1:0];
         clamp_sat = 1'b1;
      end else if (q < I_MIN) begin
         clamp_i   = I_MIN[I_W-1:0];
         clamp_sat = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         run_en  <= 1'b0;
         v_prev  <= '0;
         s1_vld  <= 1'b0;
         s1_d    <= '0;
         s2_vld  <= 1'b0;
         s2_p    <= '0;
         m_valid <= 1'b0;
         m_i     <= '0;
         m_sat   <= 1'b0;
      end else begin
         run_en <= 1'b1;
         if (clear) begin
            // Anything in flight is discarded; the next accepted sample only primes.
            state   <= EMPTY;
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            m_valid <= 1'b0;
         end else if (advance) begin
            s1_vld <= accept && (state == PRIMED);
            if (accept) begin
               v_prev <= s_vout;
               state  <= PRIMED;
               if (state == PRIMED) begin
                  s1_d <= diff;
               end
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
               s2_p <= prod;
            end
            m_valid <= s2_vld;
            if (s2_vld) begin
               m_i   <= clamp_i;
               m_sat <= clamp_sat;
            end
         end
      end
   end

   // Delivery bookkeeping; clear wins even when a transfer completes on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt <= '0;
         sat_sticky <= 1'b0;
      end else if (clear) begin
         sample_cnt <= '0;
         sat_sticky <= 1'b0;
      end else if (m_valid && m_ready) begin
         if (sample_cnt != {CNT_W{1'b1}}) begin
            sample_cnt <= sample_cnt + 1'b1;
         end
         if (m_sat) begin
            sat_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cap_current_estimator.sv
module tb_cap_current_estimator;

   logic               clk;
   logic               rst_n;
   logic               clear;
   logic               s_valid;
   logic               s_ready;
   logic signed [23:0] s_vout;
   logic               m_valid;
   logic               m_ready;
   logic signed [15:0] m_i;
   logic               m_sat;
   logic [31:0]        sample_cnt;
   logic               sat_sticky;

   int n_chk  = 0;
   int n_fail = 0;

   cap_current_estimator #(
      .V_W(24), .I_W(16), .GAIN(25), .SHIFT(0), .CNT_W(32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_vout     (s_vout),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_i        (m_i),
      .m_sat      (m_sat),
      .sample_cnt (sample_cnt),
      .sat_sticky (sat_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic               vld;
      logic signed [23:0] vout;
      logic               rdy;
      logic               clr;
      logic               mv;
      int                 mi;
      logic               ms;
      int                 cnt;
      logic               sticky;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(input logic vld, input int vout, input logic rdy, input logic clr,
                               input logic mv, input int mi, input logic ms, input int cnt,
                               input logic st);
      vec_t v;
      v.vld    = vld;
      v.vout   = 24'(vout);
      v.rdy    = rdy;
      v.clr    = clr;
      v.mv     = mv;
      v.mi     = mi;
      v.ms     = ms;
      v.cnt    = cnt;
      v.sticky = st;
      return v;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input int vout);
      s_valid = vld;
      s_vout  = 24'(vout);
   endtask

   int idx;
   int delivered;
   int stall;
   logic seen;
   logic signed [23:0] stream[5];

   initial begin
      rst_n   = 1'b0;
      clear   = 1'b0;
      s_valid = 1'b0;
      s_vout  = '0;
      m_ready = 1'b1;
      stream  = '{24'sd0, 24'sd40, 24'sd80, 24'sd120, 24'sd160};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_i", m_i, 0);
      chk("rst_m_sat", m_sat, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_sample_cnt", sample_cnt, 0);
      chk("rst_sat_sticky", sat_sticky, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst_s_ready", s_ready, 1);

      // Table: ramp, negative slope, constant, saturation both ways
      vecs[0]  = mk(1, 100,  1, 0, 0, 0,      0, 0, 0);
      vecs[1]  = mk(1, 140,  1, 0, 0, 0,      0, 0, 0);
      vecs[2]  = mk(1, 180,  1, 0, 0, 0,      0, 0, 0);
      vecs[3]  = mk(1, 220,  1, 0, 1, 1000,   0, 0, 0);
      vecs[4]  = mk(0, 0,    1, 0, 1, 1000,   0, 1, 0);
      vecs[5]  = mk(0, 0,    1, 0, 1, 1000,   0, 2, 0);
      vecs[6]  = mk(0, 0,    1, 0, 0, 0,      0, 3, 0);
      vecs[7]  = mk(0, 0,    1, 1, 0, 0,      0, 0, 0);
      vecs[8]  = mk(1, 500,  1, 0, 0, 0,      0, 0, 0);
      vecs[9]  = mk(1, 420,  1, 0, 0, 0,      0, 0, 0);
      vecs[10] = mk(1, 420,  1, 0, 0, 0,      0, 0, 0);
      vecs[11] = mk(0, 0,    1, 0, 1, -2000,  0, 0, 0);
      vecs[12] = mk(0, 0,    1, 0, 1, 0,      0, 1, 0);
      vecs[13] = mk(0, 0,    1, 0, 0, 0,      0, 2, 0);
      vecs[14] = mk(0, 0,    1, 1, 0, 0,      0, 0, 0);
      vecs[15] = mk(1, 0,    1, 0, 0, 0,      0, 0, 0);
      vecs[16] = mk(1, 2000, 1, 0, 0, 0,      0, 0, 0);
      vecs[17] = mk(1, 0,    1, 0, 0, 0,      0, 0, 0);
      vecs[18] = mk(0, 0,    1, 0, 1, 32767,  1, 0, 0);
      vecs[19] = mk(0, 0,    1, 0, 1, -32768, 1, 1, 1);
      vecs[20] = mk(0, 0,    1, 0, 0, 0,      0, 2, 1);

      for (int i = 0; i < 21; i++) begin
         s_valid = vecs[i].vld;
         s_vout  = vecs[i].vout;
         m_ready = vecs[i].rdy;
         clear   = vecs[i].clr;
         step();
         clear = 1'b0;
         chk($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].mv);
         if (vecs[i].mv) begin
            chk($sformatf("vec%0d_m_i", i), m_i, vecs[i].mi);
            chk($sformatf("vec%0d_m_sat", i), m_sat, vecs[i].ms);
         end
         chk($sformatf("vec%0d_sample_cnt", i), sample_cnt, vecs[i].cnt);
         chk($sformatf("vec%0d_sat_sticky", i), sat_sticky, vecs[i].sticky);
      end

      // Backpressure: 5-cycle stall starting at the first m_valid
      drive(0, 0);
      clear = 1'b1;
      step();
      clear     = 1'b0;
      idx       = 0;
      seen      = 1'b0;
      stall     = 0;
      delivered = 0;
      for (int c = 0; c < 30; c++) begin
         if (m_valid && !seen) begin
            seen  = 1'b1;
            stall = 5;
         end
         m_ready = (stall == 0);
         if (idx < 5) drive(1, stream[idx]);
         else drive(0, 0);
         #1;
         if (stall > 0) begin
            chk("bp_s_ready_stalled", s_ready, 0);
            chk("bp_m_valid_held", m_valid, 1);
            chk("bp_m_i_held", m_i, 1000);
            stall--;
         end
         if (m_valid && m_ready) begin
            delivered++;
            chk("bp_m_i", m_i, 1000);
         end
         if (s_valid && s_ready) idx++;
         step();
      end
      chk("bp_accepted", idx, 5);
      chk("bp_delivered", delivered, 4);
      chk("bp_sample_cnt", sample_cnt, 4);

      // Clear mid-stream, coinciding with a completing transfer
      m_ready = 1'b1;
      drive(1, 0);
      step();
      drive(1, 40);
      step();
      drive(1, 80);
      step();
      drive(0, 0);
      step();
      chk("clr_pre_m_valid", m_valid, 1);
      chk("clr_pre_m_i", m_i, 1000);
      clear = 1'b1;
      #1;
      chk("clr_s_ready", s_ready, 0);
      step();
      clear = 1'b0;
      chk("clr_m_valid", m_valid, 0);
      chk("clr_sample_cnt", sample_cnt, 0);
      step();
      chk("clr_flush1_m_valid", m_valid, 0);
      step();
      chk("clr_flush2_m_valid", m_valid, 0);
      drive(1, 1000);
      step();
      drive(1, 1040);
      step();
      chk("clr_prime1_m_valid", m_valid, 0);
      drive(0, 0);
      step();
      chk("clr_prime2_m_valid", m_valid, 0);
      step();
      chk("clr_after_m_valid", m_valid, 1);
      chk("clr_after_m_i", m_i, 1000);
      chk("clr_after_m_sat", m_sat, 0);

      // Asynchronous reset between edges while outputs are active
      for (int k = 0; k < 4; k++) begin
         drive(1, 40 * k);
         step();
      end
      drive(0, 0);
      step();
      chk("ar_pre_m_valid", m_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_m_valid", m_valid, 0);
      chk("ar_m_i", m_i, 0);
      chk("ar_s_ready", s_ready, 0);
      chk("ar_sample_cnt", sample_cnt, 0);
      chk("ar_sat_sticky", sat_sticky, 0);
      step();
      rst_n = 1'b1;
      step();
      drive(1, 500);
      #1;
      chk("ar_rel_s_ready", s_ready, 1);
      step();
      drive(0, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("ar_prime_m_valid", m_valid, 0);
      end
      drive(1, 540);
      step();
      drive(0, 0);
      step();
      chk("ar_lat1_m_valid", m_valid, 0);
      step();
      chk("ar_out_m_valid", m_valid, 1);
      chk("ar_out_m_i", m_i, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
